mips_instr_mem_harvard: RTL



---
 rtl/mips_instr_mem_harvard_pkg.sv | 23 ++
 rtl/mips_instr_mem_harvard_if.sv | 40 ++++
 rtl/mips_instr_mem_harvard_monitor.sv | 89 ++++++++
 rtl/mips_instr_mem_harvard.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mips_instr_mem_harvard_pkg.sv
// Shared types and helpers for the Harvard MIPS instruction-memory model
// and its run monitor.
//   imem_state_t : run-monitor FSM states
//   RESET_VECTOR : default byte address of instruction word 0
//   byte_swap32  : reverses the four bytes of a 32-bit word
package mips_tb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } imem_state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

  // The CPU instruction port expects the stored big-endian word with its
  // bytes reversed, i.e. {b0,b1,b2,b3}.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mips_instr_mem_harvard_if.sv
// Bus bundle between the bench stimulus / CPU and the instruction-memory
// model.
//   master : bench side; drives load port, fetch address, CPU status
//   slave  : memory model side; returns fetched word and run flags
// Signals: clk_enable, load_en, load_index, load_data, instr_address,
// active, register_v0 (master -> slave); instr_readdata, done, timed_out,
// fault, cycle_count, result_v0 (slave -> master).
interface mips_instr_mem_harvard_if #(
  parameter int DEPTH = 64
);

  localparam int IDX_W = $clog2(DEPTH);

  logic             clk_enable;
  logic             load_en;
  logic [IDX_W-1:0] load_index;
  logic [31:0]      load_data;
  logic [31:0]      instr_address;
  logic             active;
  logic [31:0]      register_v0;
  logic [31:0]      instr_readdata;
  logic             done;
  logic             timed_out;
  logic             fault;
  logic [31:0]      cycle_count;
  logic [31:0]      result_v0;

  modport master (
    output clk_enable, load_en, load_index, load_data,
           instr_address, active, register_v0,
    input  instr_readdata, done, timed_out, fault, cycle_count, result_v0
  );

  modport slave (
    input  clk_enable, load_en, load_index, load_data,
           instr_address, active, register_v0,
    output instr_readdata, done, timed_out, fault, cycle_count, result_v0
  );

endinterface

// File: rtl/mips_instr_mem_harvard_monitor.sv
// Run monitor: tracks the CPU run with a four-state FSM, counts RUN cycles,
// detects halt (signalled by the caller through halt_i) and timeout, and
// captures v0 on the halt edge.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   clk_enable_i   : gates cycle counting and the timeout check
//   active_i       : CPU active flag, starts the run from IDLE
//   halt_i         : fetch of address 0 with active low
//   register_v0_i  : CPU v0, sampled on the halt edge
//   state_o        : current FSM state
//   done_o, timed_out_o, cycle_count_o, result_v0_o : registered run status
module mips_run_monitor
  import mips_tb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable_i,
  input  logic        active_i,
  input  logic        halt_i,
  input  logic [31:0] register_v0_i,
  output imem_state_t state_o,
  output logic        done_o,
  output logic        timed_out_o,
  output logic [31:0] cycle_count_o,
  output logic [31:0] result_v0_o
);

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  imem_state_t state_q;
  logic        done_q;
  logic        timed_out_q;
  logic [31:0] cycle_count_q;
  logic [31:0] cycle_count_d;
  logic [31:0] result_v0_q;

  // Saturating increment of the run-cycle counter when the clock is enabled.
  always_comb begin
    cycle_count_d = cycle_count_q;
    if (clk_enable_i && (cycle_count_q != 32'hFFFFFFFF)) begin
      cycle_count_d = cycle_count_q + 32'd1;
    end
  end

  // Run FSM. Halt has priority over timeout on the same edge. The counter
  // is left untouched on the exit edge, so after a timeout it reads
  // TIMEOUT_CYCLES-1 alongside timed_out. DONE and TIMEOUT hold until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      done_q        <= 1'b0;
      timed_out_q   <= 1'b0;
      cycle_count_q <= 32'd0;
      result_v0_q   <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (active_i) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (halt_i) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            result_v0_q <= register_v0_i;
          end else if (clk_enable_i && (cycle_count_q == TIMEOUT_LAST)) begin
            state_q     <= TIMEOUT;
            timed_out_q <= 1'b1;
          end else begin
            cycle_count_q <= cycle_count_d;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign state_o       = state_q;
  assign done_o        = done_q;
  assign timed_out_o   = timed_out_q;
  assign cycle_count_o = cycle_count_q;
  assign result_v0_o   = result_v0_q;

endmodule

// File: rtl/mips_instr_mem_harvard.sv
// Instruction-memory model for the Harvard MIPS benches: program storage
// with a load port, fetch decode relative to BASE_ADDR, optional byte swap,
// optional registered read, illegal-fetch detection, and a run monitor.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   imem       : slave side of mips_instr_mem_harvard_if (load port, fetch
//                address/data, CPU status in, run flags out)
// Optional build macro MIPS_IMEM_TRACE_EN: prints a per-cycle fetch trace and
// the halt/timeout outcome. Without it the module has no display output.
module mips_instr_mem_harvard
  import mips_tb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = RESET_VECTOR,
  parameter int          DEPTH          = 64,
  parameter int          LATENCY        = 0,
  parameter int          SWAP_BYTES     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  mips_instr_mem_harvard_if.slave  imem
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      offset;
  logic [IDX_W-1:0] fetch_idx;
  logic             fetch_valid;
  logic             halt;
  logic [31:0]      raw_word;
  logic [31:0]      out_word;
  logic             fault_q;
  imem_state_t      state;

  // Offset wraps modulo 2^32, so addresses below BASE_ADDR (including the
  // halt address 0) land far out of range and decode as invalid.
  assign offset      = imem.instr_address - BASE_ADDR;
  assign fetch_idx   = offset[IDX_W+1:2];
  assign fetch_valid = (imem.instr_address[1:0] == 2'b00) && (offset < SPAN);
  assign halt        = (imem.instr_address == 32'd0) && !imem.active;
  assign raw_word    = fetch_valid ? mem_q[fetch_idx] : 32'h00000000;
  assign out_word    = (SWAP_BYTES != 0) ? byte_swap32(raw_word) : raw_word;

  // Program load is only honoured while the monitor is IDLE; the array is
  // not reset so a program can be loaded while reset is held.
  always_ff @(posedge clk) begin
    if (imem.load_en && (state == IDLE)) begin
      mem_q[imem.load_index] <= imem.load_data;
    end
  end

  // Sticky fault for any illegal fetch during RUN other than the halt fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if ((state == RUN) && !fetch_valid && !halt) begin
      fault_q <= 1'b1;
    end
  end

  generate
    if (LATENCY == 0) begin : g_comb_read
      assign imem.instr_readdata = out_word;
    end else begin : g_reg_read
      logic [31:0] rdata_q;
      logic [31:0] rdata_d;

      assign rdata_d = imem.clk_enable ? out_word : rdata_q;

      // Registered read: advances only on enabled edges, otherwise holds.
      always_ff @(posedge clk) begin
        if (reset) begin
          rdata_q <= 32'd0;
        end else begin
          rdata_q <= rdata_d;
        end
      end

      assign imem.instr_readdata = rdata_q;
    end
  endgenerate

  mips_run_monitor #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_monitor (
    .clk           (clk),
    .reset         (reset),
    .clk_enable_i  (imem.clk_enable),
    .active_i      (imem.active),
    .halt_i        (halt),
    .register_v0_i (imem.register_v0),
    .state_o       (state),
    .done_o        (imem.done),
    .timed_out_o   (imem.timed_out),
    .cycle_count_o (imem.cycle_count),
    .result_v0_o   (imem.result_v0)
  );

  assign imem.fault = fault_q;

`ifdef MIPS_IMEM_TRACE_EN
  imem_state_t trace_prev_q;

  // Trace output; the outcome messages fire on the first cycle spent in
  // DONE/TIMEOUT, once the captured values are visible.
  always_ff @(posedge clk) begin
    trace_prev_q <= state;
    if (!reset) begin
      if ((state == RUN) && imem.clk_enable) begin
        $display("IMEM : cycle %0d addr %h word %h",
                 imem.cycle_count, imem.instr_address, raw_word);
      end
      if ((state == DONE) && (trace_prev_q != DONE)) begin
        $display("CPU : OUT : %0d", imem.result_v0);
      end
      if ((state == TIMEOUT) && (trace_prev_q != TIMEOUT)) begin
        $display("TB : TIMEOUT");
      end
    end
  end
`endif

endmodule
